// File: rtl/sev_seg_pkg.sv
// Shared constants for the seven-segment multiplexer: segment bit positions
// and the active-high hex-to-segment table (gfedcba, bit 0 = segment a).
package sev_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Entry n is the pattern for nibble n; listed from F down to 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sev_seg_decode.sv
// Combinational nibble to active-high seven-segment pattern.
module sev_seg_decode
  import sev_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/sev_seg_mux.sv
// Time-multiplexed N-digit seven-segment controller with frame-synchronous
// input shadowing, leading-zero suppression, blanking and PWM brightness.
module sev_seg_mux
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 131072,
  parameter int BRIGHT_W       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                            : {NUM_DIGITS{1'b0}};

  logic [PRE_W-1:0]        r_pre;
  logic [IDX_W-1:0]        r_idx;
  logic [BRIGHT_W-1:0]     r_pwm;

  logic [4*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS-1:0]   r_dp_in;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic                    r_lz_en;
  logic [BRIGHT_W-1:0]     r_bright;

  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic                    r_frame_start;

  logic                    w_pre_tc;
  logic                    w_idx_last;
  logic                    w_latch;
  logic                    w_lead;
  logic [NUM_DIGITS-1:0]   w_sup;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic                    w_blank_sel;
  logic                    w_sup_sel;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_pat;
  logic                    w_pwm_on;
  logic                    w_an_on;
  logic [6:0]              w_seg_hi;
  logic                    w_dp_hi;
  logic [NUM_DIGITS-1:0]   w_an_hi;

  assign w_pre_tc   = (r_pre == PRE_W'(TICK_DIV - 1));
  assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_latch    = w_pre_tc & w_idx_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
      if (w_pre_tc) begin
        r_pre <= '0;
        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  // Shadow copies: the display only ever looks at these, so mid-frame
  // input changes cannot tear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_dp_in  <= '0;
      r_blank  <= '1;
      r_lz_en  <= 1'b0;
      r_bright <= '0;
    end else if (w_latch) begin
      r_data   <= data;
      r_dp_in  <= dp_in;
      r_blank  <= blank;
      r_lz_en  <= lz_en;
      r_bright <= brightness;
    end
  end

  // Zeros are suppressed from the top digit down until the first nonzero;
  // digit 0 is never included.
  always_comb begin
    w_sup  = '0;
    w_lead = r_lz_en;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_lead   = w_lead & (r_data[4*i +: 4] == 4'h0);
      w_sup[i] = w_lead;
    end
  end

  always_comb begin
    w_nib       = '0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    w_sup_sel   = 1'b0;
    w_onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_data[4*i +: 4];
        w_dp_sel    = r_dp_in[i];
        w_blank_sel = r_blank[i];
        w_sup_sel   = w_sup[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  sev_seg_decode u_decode (
    .i_nib (w_nib),
    .o_seg (w_pat)
  );

  assign w_pwm_on = (r_bright == '1) || (r_pwm < r_bright);
  assign w_an_on  = w_pwm_on && (r_pre != '0);
  assign w_seg_hi = (w_blank_sel || w_sup_sel) ? 7'h00 : w_pat;
  assign w_dp_hi  = w_dp_sel & ~w_blank_sel;
  assign w_an_hi  = w_an_on ? w_onehot : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg         <= SEG_OFF;
      r_dp          <= DP_OFF;
      r_anode       <= AN_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
      r_dp          <= SEG_ACTIVE_LOW ? ~w_dp_hi  : w_dp_hi;
      r_anode       <= AN_ACTIVE_LOW  ? ~w_an_hi  : w_an_hi;
      r_frame_start <= w_latch;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign anode       = r_anode;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sev_seg_mux.sv
// Directed bench for sev_seg_mux with 4 digits, 8-cycle slots, active-low pins.
module tb_sev_seg_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        lz_en;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  anode;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sev_seg_mux #(
    .NUM_DIGITS     (4),
    .TICK_DIV       (8),
    .BRIGHT_W       (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .dp_in       (dp_in),
    .blank       (blank),
    .lz_en       (lz_en),
    .brightness  (brightness),
    .seg         (seg),
    .dp          (dp),
    .anode       (anode),
    .frame_start (frame_start)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        lz;
    logic [3:0]  bright;
    int          slot;
    int          pre;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs();
    bit found = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        found = 1;
        break;
      end
    end
    chk("frame_start_seen", {31'd0, found}, 32'd1);
  endtask

  // Entered with rst just asserted at a negedge.
  task automatic reset_seq(input string tag);
    bit dark_bad = 0;
    int fs_at = 0;
    #1;
    chk({tag, "_rst_anode"}, {28'd0, anode}, 32'hF);
    chk({tag, "_rst_seg"},   {25'd0, seg},   32'h7F);
    chk({tag, "_rst_dp"},    {31'd0, dp},    32'd1);
    chk({tag, "_rst_fs"},    {31'd0, frame_start}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (anode !== 4'hF) dark_bad = 1;
      if (frame_start === 1'b1 && fs_at == 0) fs_at = k;
    end
    chk({tag, "_dark_33"}, {31'd0, dark_bad}, 32'd0);
    chk({tag, "_first_fs"}, fs_at, 32);
    step(1);
    chk({tag, "_first_lit"}, {28'd0, anode}, 32'hE);
  endtask

  initial begin
    int n;
    vecs[0]  = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF, 0, 3, 7'h0E, 1'b1, 4'hE};
    vecs[1]  = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF, 1, 3, 7'h08, 1'b1, 4'hD};
    vecs[2]  = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF, 2, 3, 7'h24, 1'b1, 4'hB};
    vecs[3]  = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF, 3, 7, 7'h79, 1'b1, 4'h7};
    vecs[4]  = '{16'h0070, 4'h0, 4'h0, 1'b1, 4'hF, 3, 3, 7'h7F, 1'b1, 4'h7};
    vecs[5]  = '{16'h0070, 4'h0, 4'h0, 1'b1, 4'hF, 2, 3, 7'h7F, 1'b1, 4'hB};
    vecs[6]  = '{16'h0070, 4'h0, 4'h0, 1'b1, 4'hF, 1, 3, 7'h78, 1'b1, 4'hD};
    vecs[7]  = '{16'h0070, 4'h0, 4'h0, 1'b1, 4'hF, 0, 3, 7'h40, 1'b1, 4'hE};
    vecs[8]  = '{16'h0000, 4'h0, 4'h0, 1'b1, 4'hF, 3, 3, 7'h7F, 1'b1, 4'h7};
    vecs[9]  = '{16'h0000, 4'h0, 4'h0, 1'b1, 4'hF, 0, 3, 7'h40, 1'b1, 4'hE};
    vecs[10] = '{16'h0000, 4'h0, 4'h0, 1'b0, 4'hF, 3, 3, 7'h40, 1'b1, 4'h7};
    vecs[11] = '{16'h0070, 4'h4, 4'h1, 1'b0, 4'hF, 2, 3, 7'h40, 1'b0, 4'hB};
    vecs[12] = '{16'h0070, 4'h4, 4'h1, 1'b0, 4'hF, 0, 3, 7'h7F, 1'b1, 4'hE};
    vecs[13] = '{16'h0070, 4'h4, 4'h1, 1'b0, 4'hF, 1, 3, 7'h78, 1'b1, 4'hD};
    vecs[14] = '{16'h0005, 4'h8, 4'h0, 1'b1, 4'hF, 3, 3, 7'h7F, 1'b0, 4'h7};
    vecs[15] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'h4, 0, 2, 7'h0E, 1'b1, 4'hE};
    vecs[16] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'h4, 0, 5, 7'h0E, 1'b1, 4'hF};
    vecs[17] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'h4, 1, 2, 7'h08, 1'b1, 4'hF};
    vecs[18] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'h0, 0, 2, 7'h0E, 1'b1, 4'hF};
    vecs[19] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF, 1, 0, 7'h08, 1'b1, 4'hF};
    vecs[20] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'hE, 1, 5, 7'h08, 1'b1, 4'hD};
    vecs[21] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'hE, 1, 6, 7'h08, 1'b1, 4'hF};
    vecs[22] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'h4, 2, 3, 7'h24, 1'b1, 4'hB};

    data = 16'h12AF; dp_in = 4'h0; blank = 4'h0; lz_en = 1'b0; brightness = 4'hF;
    @(negedge clk);
    reset_seq("por");

    // Frame period
    wait_fs();
    n = 0;
    do begin
      step(1);
      n++;
    end while (frame_start !== 1'b1 && n < 40);
    chk("frame_period", n, 32);

    foreach (vecs[i]) begin
      data = vecs[i].data; dp_in = vecs[i].dp_in; blank = vecs[i].blank;
      lz_en = vecs[i].lz; brightness = vecs[i].bright;
      wait_fs();
      step(1 + vecs[i].slot * 8 + vecs[i].pre);
      chk($sformatf("vec%0d_seg", i),   {25'd0, seg},   {25'd0, vecs[i].seg});
      chk($sformatf("vec%0d_dp", i),    {31'd0, dp},    {31'd0, vecs[i].dp});
      chk($sformatf("vec%0d_anode", i), {28'd0, anode}, {28'd0, vecs[i].an});
    end

    // Mid-frame data change must not show until the next latch
    data = 16'h1111; dp_in = 4'h0; blank = 4'h0; lz_en = 1'b0; brightness = 4'hF;
    wait_fs();
    wait_fs();
    step(1 + 16 + 1);
    data = 16'h2222;
    step(10);
    chk("tear_slot3_seg", {25'd0, seg}, 32'h79);
    chk("tear_slot3_an", {28'd0, anode}, 32'h7);
    wait_fs();
    chk("tear_fs_seg", {25'd0, seg}, 32'h79);
    step(1);
    chk("new_s0p0_seg", {25'd0, seg}, 32'h24);
    chk("new_s0p0_an", {28'd0, anode}, 32'hF);
    step(1);
    chk("new_s0p1_seg", {25'd0, seg}, 32'h24);
    chk("new_s0p1_an", {28'd0, anode}, 32'hE);

    // Asynchronous reset in slot 3
    data = 16'h12AF;
    wait_fs();
    step(1 + 24 + 3);
    chk("pre_rst_an", {28'd0, anode}, 32'h7);
    rst = 1'b1;
    reset_seq("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
